sound_length_unit: RTL and testbench

Multi-channel length-counter unit for the APU. It replaces the single-channel length counter with one parametrised block holding NUM_CH independent down-counters. All state is synchronous to clk_length_ctr and advances on a one-cycle frame-sequencer tick strobe. Each channel produces a gate (`enable`) that the channel generators AND into their output. Per-channel length width is selectable, so channel 3 (8-bit) and channels 1/2/4 (6-bit) share one instance.

---
 rtl/sound_length_unit.sv | 173 +++++++++++++++++
 tb/tb_sound_length_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sound_length_unit.sv
// sound_length_unit: multi-channel APU length counters.
// NUM_CH independent down-counters clocked by the frame-sequencer len_tick
// strobe. Each channel gates its generator through enable[i].
// Per-channel length width is set by WIDE_MASK (wide or narrow field).
// Optional build macro: SOUND_LEN_EXTRA_CLK_EN models the DMG extra length
// clock that fires when the length-enable bit rises in the half of the
// frame-sequencer period where the next tick will not clock length.

// One length-counter channel. LW is this channel's length field width and
// CW is the counter width shared by all channels (wide width + 1).
module sound_length_lane #(
    parameter int CW = 9,
    parameter int LW = 6
) (
    input  logic          clk_length_ctr,
    input  logic          rst,
    input  logic          i_apu_on,
    input  logic          i_tick,
    input  logic          i_wr,
    input  logic [CW-2:0] i_data,
    input  logic          i_trigger,
    input  logic          i_single,
`ifdef SOUND_LEN_EXTRA_CLK_EN
    input  logic          i_phase,
`endif
    output logic          o_enable,
    output logic [CW-1:0] o_cnt
);

    // Full-scale count for this channel (2^LW), and the mask for len_data.
    localparam logic [CW-1:0] MAXV = CW'(1) << LW;
    localparam logic [CW-1:0] MASK = MAXV - CW'(1);

    logic [CW-1:0] r_cnt;
    logic          r_en;
    logic [CW-1:0] w_load;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_en_nxt;
`ifdef SOUND_LEN_EXTRA_CLK_EN
    logic          r_single_q;
    logic          w_extra;
`endif

    // Written length is stored as remaining count; 0 naturally loads MAXV.
    assign w_load = MAXV - ({1'b0, i_data} & MASK);

    // Next-state resolution with priority write > trigger > tick.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_en_nxt  = r_en;
`ifdef SOUND_LEN_EXTRA_CLK_EN
        w_extra   = 1'b0;
`endif
        if (i_wr) begin
            w_cnt_nxt = w_load;
        end
        if (i_trigger) begin
            w_en_nxt = 1'b1;
            if (w_cnt_nxt == '0) begin
                w_cnt_nxt = MAXV;
            end
        end else if (!i_wr && i_tick && i_single && (r_cnt != '0)) begin
            // Tick is only honoured when nothing else touched the channel.
            w_cnt_nxt = r_cnt - CW'(1);
            if (w_cnt_nxt == '0) begin
                w_en_nxt = 1'b0;
            end
        end
`ifdef SOUND_LEN_EXTRA_CLK_EN
        // Length-enable rising in the non-clocking half gets one extra
        // decrement, applied on top of any write/trigger reload.
        w_extra = i_phase && i_single && !r_single_q && (w_cnt_nxt != '0);
        if (w_extra) begin
            w_cnt_nxt = w_cnt_nxt - CW'(1);
            if ((w_cnt_nxt == '0) && !i_trigger) begin
                w_en_nxt = 1'b0;
            end
        end
`endif
    end

    // Channel state: async reset, synchronous clear while the APU is off.
    always_ff @(posedge clk_length_ctr or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_en  <= 1'b0;
`ifdef SOUND_LEN_EXTRA_CLK_EN
            r_single_q <= 1'b0;
`endif
        end else if (!i_apu_on) begin
            r_cnt <= '0;
            r_en  <= 1'b0;
`ifdef SOUND_LEN_EXTRA_CLK_EN
            r_single_q <= 1'b0;
`endif
        end else begin
            r_cnt <= w_cnt_nxt;
            r_en  <= w_en_nxt;
`ifdef SOUND_LEN_EXTRA_CLK_EN
            r_single_q <= i_single;
`endif
        end
    end

    assign o_enable = r_en;
    assign o_cnt    = r_cnt;

endmodule

module sound_length_unit #(
    parameter int                NUM_CH       = 4,
    parameter int                WIDE_WIDTH   = 8,
    parameter int                NARROW_WIDTH = 6,
    parameter logic [NUM_CH-1:0] WIDE_MASK    = 4'b0100
) (
    input  logic                           clk_length_ctr,
    input  logic                           rst,
    input  logic                           apu_on,
    input  logic                           len_tick,
    input  logic [NUM_CH-1:0]              len_wr,
    input  logic [WIDE_WIDTH-1:0]          len_data,
    input  logic [NUM_CH-1:0]              trigger,
    input  logic [NUM_CH-1:0]              single,
    output logic [NUM_CH-1:0]              enable,
    output logic [NUM_CH*(WIDE_WIDTH+1)-1:0] len_left
);

    localparam int CW = WIDE_WIDTH + 1;

    logic [NUM_CH-1:0][CW-1:0] w_cnt;

`ifdef SOUND_LEN_EXTRA_CLK_EN
    // Frame-sequencer half tracker: 1 means the next tick will not clock length.
    logic r_phase;

    // Phase toggles on every length tick and restarts with the APU.
    always_ff @(posedge clk_length_ctr or posedge rst) begin
        if (rst) begin
            r_phase <= 1'b0;
        end else if (!apu_on) begin
            r_phase <= 1'b0;
        end else if (len_tick) begin
            r_phase <= ~r_phase;
        end
    end
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int LW = WIDE_MASK[i] ? WIDE_WIDTH : NARROW_WIDTH;

        sound_length_lane #(
            .CW(CW),
            .LW(LW)
        ) u_lane (
            .clk_length_ctr (clk_length_ctr),
            .rst            (rst),
            .i_apu_on       (apu_on),
            .i_tick         (len_tick),
            .i_wr           (len_wr[i]),
            .i_data         (len_data),
            .i_trigger      (trigger[i]),
            .i_single       (single[i]),
`ifdef SOUND_LEN_EXTRA_CLK_EN
            .i_phase        (r_phase),
`endif
            .o_enable       (enable[i]),
            .o_cnt          (w_cnt[i])
        );
    end

    assign len_left = w_cnt;

endmodule

// File: tb/tb_sound_length_unit.sv
// Directed bench for sound_length_unit with hand-computed expectations.
module tb_sound_length_unit;

    localparam int NUM_CH = 4;
    localparam int CW     = 9;

    logic                   clk_length_ctr;
    logic                   rst;
    logic                   apu_on;
    logic                   len_tick;
    logic [NUM_CH-1:0]      len_wr;
    logic [7:0]             len_data;
    logic [NUM_CH-1:0]      trigger;
    logic [NUM_CH-1:0]      single;
    logic [NUM_CH-1:0]      enable;
    logic [NUM_CH*CW-1:0]   len_left;

    int n_assert = 0;
    int n_fail   = 0;

    sound_length_unit dut (
        .clk_length_ctr (clk_length_ctr),
        .rst            (rst),
        .apu_on         (apu_on),
        .len_tick       (len_tick),
        .len_wr         (len_wr),
        .len_data       (len_data),
        .trigger        (trigger),
        .single         (single),
        .enable         (enable),
        .len_left       (len_left)
    );

    initial clk_length_ctr = 1'b0;
    always #5 clk_length_ctr = ~clk_length_ctr;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk_length_ctr);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            len_tick = 1'b1;
            step();
        end
        len_tick = 1'b0;
    endtask

    function automatic logic [31:0] cnt(input int ch);
        return 32'(len_left[ch*CW +: CW]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; apu_on = 1'b1; len_tick = 1'b0; len_wr = '0;
        len_data = '0; trigger = '0; single = '0;
        #23;
        chk("rst_enable", 32'(enable), 0);
        chk("rst_len_left", 32'(len_left == '0), 1);
        rst = 1'b0;
        step();

        // 1: idle ticks with counters at zero never wrap
        single = 4'hF;
        ticks(10);
        chk("idle_enable", 32'(enable), 0);
        chk("idle_len_left", 32'(len_left == '0), 1);
        single = 4'h0;

        // 2: ch0 narrow, 64-60 = 4 ticks
        len_wr = 4'b0001; len_data = 8'd60; step(); len_wr = '0;
        chk("c0_load", cnt(0), 4);
        chk("c0_wr_no_en", 32'(enable[0]), 0);
        trigger = 4'b0001; step(); trigger = '0;
        chk("c0_trig_en", 32'(enable[0]), 1);
        single[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            ticks(1);
            chk("c0_tick_cnt", cnt(0), 32'(4 - k));
            chk("c0_tick_en", 32'(enable[0]), (k < 4) ? 1 : 0);
        end

        // 3: ch2 wide, trigger from zero loads 256
        trigger = 4'b0100; step(); trigger = '0;
        chk("c2_trig_cnt", cnt(2), 256);
        chk("c2_trig_en", 32'(enable[2]), 1);
        single[2] = 1'b1;
        ticks(255);
        chk("c2_255_cnt", cnt(2), 1);
        chk("c2_255_en", 32'(enable[2]), 1);
        ticks(1);
        chk("c2_256_cnt", cnt(2), 0);
        chk("c2_256_en", 32'(enable[2]), 0);
        ticks(1);
        chk("c2_nowrap", cnt(2), 0);

        // 4: ch1 length enable off holds count; realign phase first
        ticks(1);
        len_wr = 4'b0010; len_data = 8'd10; step(); len_wr = '0;
        trigger = 4'b0010; step(); trigger = '0;
        ticks(100);
        chk("c1_hold_cnt", cnt(1), 54);
        chk("c1_hold_en", 32'(enable[1]), 1);
        single[1] = 1'b1;
        ticks(53);
        chk("c1_53_cnt", cnt(1), 1);
        chk("c1_53_en", 32'(enable[1]), 1);
        ticks(1);
        chk("c1_54_cnt", cnt(1), 0);
        chk("c1_54_en", 32'(enable[1]), 0);

        // 5: simultaneous write+trigger on ch3 with tick on ch0
        single = 4'b0001;
        len_wr = 4'b0001; len_data = 8'd50; step();
        trigger = 4'b0001; len_wr = '0; step(); trigger = '0;
        len_wr = 4'b0010; len_data = 8'd20; step();
        len_wr = 4'b0100; len_data = 8'd200; step(); len_wr = '0;
        chk("s_c0_pre", cnt(0), 14);
        chk("s_c1_wr_no_en", 32'(enable[1]), 0);
        len_wr = 4'b1000; len_data = 8'd0; trigger = 4'b1000; len_tick = 1'b1;
        step();
        len_wr = '0; trigger = '0; len_tick = 1'b0;
        chk("s_c3_cnt", cnt(3), 64);
        chk("s_c0_cnt", cnt(0), 13);
        chk("s_c1_cnt", cnt(1), 44);
        chk("s_c2_cnt", cnt(2), 56);
        chk("s_enable", 32'(enable), 32'b1001);
        trigger = 4'b0001; len_tick = 1'b1; step();
        trigger = '0; len_tick = 1'b0;
        chk("s_trig_tick_cnt", cnt(0), 13);
        chk("s_trig_tick_en", 32'(enable[0]), 1);

        // 6: APU power-off clears and blocks strobes
        apu_on = 1'b0; step();
        chk("off_enable", 32'(enable), 0);
        chk("off_len_left", 32'(len_left == '0), 1);
        trigger = 4'hF; len_wr = 4'hF; len_data = 8'd3; step();
        trigger = '0; len_wr = '0;
        chk("off_ign_enable", 32'(enable), 0);
        chk("off_ign_len_left", 32'(len_left == '0), 1);
        apu_on = 1'b1; single = '0; step();
        chk("on_len_left", 32'(len_left == '0), 1);

        // Length-enable rise after an odd number of ticks
        len_wr = 4'b0001; len_data = 8'd59; step(); len_wr = '0;
        trigger = 4'b0001; step(); trigger = '0;
        ticks(1);
        chk("x_pre_cnt", cnt(0), 5);
        single[0] = 1'b1; step();
`ifdef SOUND_LEN_EXTRA_CLK_EN
        chk("x_rise_cnt", cnt(0), 4);
`else
        chk("x_rise_cnt", cnt(0), 5);
`endif
        chk("x_rise_en", 32'(enable[0]), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
